// File: rtl/cpx_buf_pkg.sv
// Shared types and parameter defaults for the CPX repeater/outstanding-tracker slice.
package cpx_buf_pkg;

  localparam int unsigned NCH_DEF     = 8;
  localparam int unsigned STAGES_DEF  = 1;
  localparam int unsigned MAX_OUT_DEF = 2;

  typedef enum logic {
    ATOM_IDLE = 1'b0,
    ATOM_PAIR = 1'b1
  } atom_state_e;

endpackage

// File: rtl/cpx_buf_pipe_if.sv
// Scache<->CPX request/grant bundle; slave is the repeater, master drives raw inputs.
interface cpx_buf_pipe_if
  import cpx_buf_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF
);
  logic [NCH-1:0] cpx_scache_grant_ca;
  logic [NCH-1:0] scache_cpx_req_cq_l;
  logic           scache_cpx_atom_cq_l;
  logic           err_clr;
  logic [NCH-1:0] cpx_scache_grant_buf_ca;
  logic [NCH-1:0] scache_cpx_req_buf_cq;
  logic           scache_cpx_atom_buf_cq;
  logic [NCH-1:0] chan_full;
  logic [NCH-1:0] err_ovf;
  logic [NCH-1:0] err_unf;
  logic           err_atom;

  modport slave (
    input  cpx_scache_grant_ca, scache_cpx_req_cq_l, scache_cpx_atom_cq_l, err_clr,
    output cpx_scache_grant_buf_ca, scache_cpx_req_buf_cq, scache_cpx_atom_buf_cq,
           chan_full, err_ovf, err_unf, err_atom
  );

  modport master (
    output cpx_scache_grant_ca, scache_cpx_req_cq_l, scache_cpx_atom_cq_l, err_clr,
    input  cpx_scache_grant_buf_ca, scache_cpx_req_buf_cq, scache_cpx_atom_buf_cq,
           chan_full, err_ovf, err_unf, err_atom
  );

endinterface

// File: rtl/cpx_out_cnt.sv
// Per-channel outstanding-request counter with sticky overflow/underflow flags.
module cpx_out_cnt
  import cpx_buf_pkg::*;
#(
  parameter int unsigned MAX_OUT = MAX_OUT_DEF
) (
  input  logic rclk,
  input  logic arst_l,
  input  logic inc,
  input  logic dec,
  input  logic err_clr,
  output logic full,
  output logic err_ovf,
  output logic err_unf
);

  localparam int unsigned     CW      = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_OUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          ovf_ev, unf_ev;

  always_comb begin
    cnt_d  = cnt_q;
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    if (inc && !dec) begin
      if (cnt_q == CNT_MAX) ovf_ev = 1'b1;
      else                  cnt_d  = cnt_q + CW'(1);
    end else if (dec && !inc) begin
      if (cnt_q == '0) unf_ev = 1'b1;
      else             cnt_d  = cnt_q - CW'(1);
    end
    // a new event wins over a coincident clear
    ovf_d = ovf_ev | (ovf_q & ~err_clr);
    unf_d = unf_ev | (unf_q & ~err_clr);
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign full    = (cnt_q == CNT_MAX);
  assign err_ovf = ovf_q;
  assign err_unf = unf_q;

endmodule

// File: rtl/cpx_buf_pipe.sv
// CPX request/grant repeater: STAGES-deep flop pipeline plus outstanding tracking
// per channel and an atomic-pair protocol checker on the buffered side.
module cpx_buf_pipe
  import cpx_buf_pkg::*;
#(
  parameter int unsigned NCH     = NCH_DEF,
  parameter int unsigned STAGES  = STAGES_DEF,
  parameter int unsigned MAX_OUT = MAX_OUT_DEF
) (
  input  logic           rclk,
  input  logic           arst_l,
  cpx_buf_pipe_if.slave  bus
);

  localparam int unsigned PW = 2 * NCH + 1;

  logic [PW-1:0]  pipe_q [STAGES];
  logic [PW-1:0]  pipe_d [STAGES];
  logic [NCH-1:0] grant_buf, req_buf;
  logic           atom_buf;
  logic [NCH-1:0] chan_full, err_ovf, err_unf;

  atom_state_e    state_q, state_d;
  logic [NCH-1:0] cap_q, cap_d;
  logic           err_atom_q, err_atom_d;
  logic           atom_ev;

  // inversion happens at the pipe entry so a cleared stage reads as "no request"
  always_comb begin
    pipe_d[0] = {bus.cpx_scache_grant_ca, ~bus.scache_cpx_req_cq_l, ~bus.scache_cpx_atom_cq_l};
    for (int unsigned s = 1; s < STAGES; s++) pipe_d[s] = pipe_q[s-1];
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      for (int unsigned s = 0; s < STAGES; s++) pipe_q[s] <= '0;
    end else begin
      for (int unsigned s = 0; s < STAGES; s++) pipe_q[s] <= pipe_d[s];
    end
  end

  assign {grant_buf, req_buf, atom_buf} = pipe_q[STAGES-1];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    cpx_out_cnt #(.MAX_OUT(MAX_OUT)) u_cnt (
      .rclk    (rclk),
      .arst_l  (arst_l),
      .inc     (req_buf[i]),
      .dec     (bus.cpx_scache_grant_ca[i]),
      .err_clr (bus.err_clr),
      .full    (chan_full[i]),
      .err_ovf (err_ovf[i]),
      .err_unf (err_unf[i])
    );
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    atom_ev = 1'b0;
    case (state_q)
      ATOM_IDLE: begin
        if (atom_buf) begin
          if (|req_buf) begin
            cap_d   = req_buf;
            state_d = ATOM_PAIR;
          end else begin
            atom_ev = 1'b1;
          end
        end
      end
      ATOM_PAIR: begin
        state_d = ATOM_IDLE;
        if (req_buf != cap_q) atom_ev = 1'b1;
      end
      default: state_d = ATOM_IDLE;
    endcase
    err_atom_d = atom_ev | (err_atom_q & ~bus.err_clr);
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q    <= ATOM_IDLE;
      cap_q      <= '0;
      err_atom_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      err_atom_q <= err_atom_d;
    end
  end

  assign bus.cpx_scache_grant_buf_ca = grant_buf;
  assign bus.scache_cpx_req_buf_cq   = req_buf;
  assign bus.scache_cpx_atom_buf_cq  = atom_buf;
  assign bus.chan_full               = chan_full;
  assign bus.err_ovf                 = err_ovf;
  assign bus.err_unf                 = err_unf;
  assign bus.err_atom                = err_atom_q;

endmodule

// File: tb/tb_cpx_buf_pipe.sv
// Bench for cpx_buf_pipe: two instances (STAGES=2 and 3) share stimulus and are
// compared every cycle against a delay-line/counter reference model.
module tb_cpx_buf_pipe;
  import cpx_buf_pkg::*;

  localparam int unsigned NCH     = 8;
  localparam int unsigned MAX_OUT = 2;
  localparam int unsigned ST_A    = 2;
  localparam int unsigned ST_B    = 3;

  logic           rclk = 1'b0;
  logic           arst_l = 1'b0;
  logic [NCH-1:0] grant, req_l;
  logic           atom_l, err_clr;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  cpx_buf_pipe_if #(.NCH(NCH)) if_a ();
  cpx_buf_pipe_if #(.NCH(NCH)) if_b ();

  assign if_a.cpx_scache_grant_ca  = grant;
  assign if_a.scache_cpx_req_cq_l  = req_l;
  assign if_a.scache_cpx_atom_cq_l = atom_l;
  assign if_a.err_clr              = err_clr;
  assign if_b.cpx_scache_grant_ca  = grant;
  assign if_b.scache_cpx_req_cq_l  = req_l;
  assign if_b.scache_cpx_atom_cq_l = atom_l;
  assign if_b.err_clr              = err_clr;

  cpx_buf_pipe #(.NCH(NCH), .STAGES(ST_A), .MAX_OUT(MAX_OUT)) dut_a (
    .rclk(rclk), .arst_l(arst_l), .bus(if_a)
  );
  cpx_buf_pipe #(.NCH(NCH), .STAGES(ST_B), .MAX_OUT(MAX_OUT)) dut_b (
    .rclk(rclk), .arst_l(arst_l), .bus(if_b)
  );

  always #5 rclk = ~rclk;

  // reference model: per instance a delay line of buffered-form values, plain counts
  int unsigned    stg [2] = '{ST_A, ST_B};
  logic [NCH-1:0] m_g [2][4];
  logic [NCH-1:0] m_r [2][4];
  logic           m_a [2][4];
  int unsigned    m_cnt [2][NCH];
  logic [NCH-1:0] m_ovf [2];
  logic [NCH-1:0] m_unf [2];
  logic [NCH-1:0] m_cap [2];
  logic           m_pair [2];
  logic           m_eatom [2];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) begin
        m_g[k][j] = '0;
        m_r[k][j] = '0;
        m_a[k][j] = 1'b0;
      end
      for (int c = 0; c < NCH; c++) m_cnt[k][c] = 0;
      m_ovf[k]   = '0;
      m_unf[k]   = '0;
      m_cap[k]   = '0;
      m_pair[k]  = 1'b0;
      m_eatom[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [NCH-1:0] rb, ovf_ev, unf_ev;
      logic           ab, ev;
      rb     = m_r[k][stg[k]-1];
      ab     = m_a[k][stg[k]-1];
      ovf_ev = '0;
      unf_ev = '0;
      for (int c = 0; c < NCH; c++) begin
        if (rb[c] && !grant[c]) begin
          if (m_cnt[k][c] == MAX_OUT) ovf_ev[c] = 1'b1;
          else m_cnt[k][c] = m_cnt[k][c] + 1;
        end else if (grant[c] && !rb[c]) begin
          if (m_cnt[k][c] == 0) unf_ev[c] = 1'b1;
          else m_cnt[k][c] = m_cnt[k][c] - 1;
        end
      end
      m_ovf[k] = ovf_ev | (err_clr ? '0 : m_ovf[k]);
      m_unf[k] = unf_ev | (err_clr ? '0 : m_unf[k]);
      ev = 1'b0;
      if (m_pair[k]) begin
        ev        = (rb != m_cap[k]);
        m_pair[k] = 1'b0;
      end else if (ab) begin
        if (rb != '0) begin
          m_cap[k]  = rb;
          m_pair[k] = 1'b1;
        end else begin
          ev = 1'b1;
        end
      end
      m_eatom[k] = ev | (m_eatom[k] & !err_clr);
      for (int j = 3; j > 0; j--) begin
        m_g[k][j] = m_g[k][j-1];
        m_r[k][j] = m_r[k][j-1];
        m_a[k][j] = m_a[k][j-1];
      end
      m_g[k][0] = grant;
      m_r[k][0] = ~req_l;
      m_a[k][0] = ~atom_l;
    end
  endtask

  task automatic check_dut(input int k, input string nm,
                           input logic [NCH-1:0] g, input logic [NCH-1:0] r, input logic a,
                           input logic [NCH-1:0] f, input logic [NCH-1:0] ov,
                           input logic [NCH-1:0] un, input logic ea);
    logic [NCH-1:0] ef;
    for (int c = 0; c < NCH; c++) ef[c] = (m_cnt[k][c] == MAX_OUT);
    check_eq({nm, " grant_buf"}, 32'(g), 32'(m_g[k][stg[k]-1]));
    check_eq({nm, " req_buf"},   32'(r), 32'(m_r[k][stg[k]-1]));
    check_eq({nm, " atom_buf"},  32'(a), 32'(m_a[k][stg[k]-1]));
    check_eq({nm, " chan_full"}, 32'(f), 32'(ef));
    check_eq({nm, " err_ovf"},   32'(ov), 32'(m_ovf[k]));
    check_eq({nm, " err_unf"},   32'(un), 32'(m_unf[k]));
    check_eq({nm, " err_atom"},  32'(ea), 32'(m_eatom[k]));
  endtask

  task automatic check_all();
    check_dut(0, "a", if_a.cpx_scache_grant_buf_ca, if_a.scache_cpx_req_buf_cq,
              if_a.scache_cpx_atom_buf_cq, if_a.chan_full, if_a.err_ovf, if_a.err_unf,
              if_a.err_atom);
    check_dut(1, "b", if_b.cpx_scache_grant_buf_ca, if_b.scache_cpx_req_buf_cq,
              if_b.scache_cpx_atom_buf_cq, if_b.chan_full, if_b.err_ovf, if_b.err_unf,
              if_b.err_atom);
  endtask

  task automatic tick();
    model_step();
    @(posedge rclk);
    #1;
    check_all();
  endtask

  task automatic set_idle();
    grant   = '0;
    req_l   = '1;
    atom_l  = 1'b1;
    err_clr = 1'b0;
  endtask

  // reset pulse taken away from the clock edge, output checked before any edge
  task automatic phase_reset();
    set_idle();
    arst_l = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge rclk);
    #1;
    arst_l = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    set_idle();
    model_reset();
    repeat (2) @(posedge rclk);
    #1;
    check_all();
    arst_l = 1'b1;

    // latency: single pulse on the STAGES=2 instance
    req_l = 8'hFE;
    tick();
    check_eq("lat_c1", 32'(if_a.scache_cpx_req_buf_cq), 32'h00);
    req_l = '1;
    tick();
    check_eq("lat_c2", 32'(if_a.scache_cpx_req_buf_cq), 32'h01);
    tick();
    check_eq("lat_c3", 32'(if_a.scache_cpx_req_buf_cq), 32'h00);

    // underflow on ch3, then coincident request+grant at full count on ch1
    phase_reset();
    grant = 8'h08;
    tick();
    grant = '0;
    check_eq("unf3_a", 32'(if_a.err_unf[3]), 32'h1);
    check_eq("unf3_b", 32'(if_b.err_unf[3]), 32'h1);
    req_l = 8'hFD;
    repeat (3) tick();
    req_l = '1;
    tick();
    grant = 8'h02;
    tick();
    grant = '0;
    check_eq("both1_full_a", 32'(if_a.chan_full[1]), 32'h1);
    check_eq("both1_ovf_a",  32'(if_a.err_ovf[1]), 32'h0);
    check_eq("both1_unf_a",  32'(if_a.err_unf[1]), 32'h0);
    repeat (2) tick();
    check_eq("both1_full_b", 32'(if_b.chan_full[1]), 32'h1);
    check_eq("both1_ovf_b",  32'(if_b.err_ovf[1]), 32'h0);

    // overflow after third request on ch0
    phase_reset();
    req_l = 8'hFE;
    repeat (3) tick();
    req_l = '1;
    tick();
    check_eq("ovf0_pre_a",  32'(if_a.err_ovf[0]), 32'h0);
    check_eq("full0_a",     32'(if_a.chan_full[0]), 32'h1);
    tick();
    check_eq("ovf0_a",      32'(if_a.err_ovf[0]), 32'h1);
    tick();
    check_eq("ovf0_b",      32'(if_b.err_ovf[0]), 32'h1);
    check_eq("full0_b",     32'(if_b.chan_full[0]), 32'h1);

    // atomic pairs: matching, then mismatching second beat
    phase_reset();
    atom_l = 1'b0; req_l = ~8'h04;
    tick();
    atom_l = 1'b1;
    tick();
    req_l = '1;
    repeat (4) tick();
    check_eq("atom_ok_a", 32'(if_a.err_atom), 32'h0);
    check_eq("atom_ok_b", 32'(if_b.err_atom), 32'h0);
    atom_l = 1'b0; req_l = ~8'h04;
    tick();
    atom_l = 1'b1; req_l = ~8'h08;
    tick();
    req_l = '1;
    repeat (4) tick();
    check_eq("atom_bad_a", 32'(if_a.err_atom), 32'h1);
    check_eq("atom_bad_b", 32'(if_b.err_atom), 32'h1);

    // reset mid-stream flushes the STAGES=3 pipe
    for (int n = 0; n < 5; n++) begin
      req_l = ~NCH'($urandom);
      grant = NCH'($urandom);
      tick();
    end
    arst_l = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("rst_req_b",   32'(if_b.scache_cpx_req_buf_cq), 32'h0);
    check_eq("rst_grant_b", 32'(if_b.cpx_scache_grant_buf_ca), 32'h0);
    @(posedge rclk);
    #1;
    check_all();
    req_l = 8'h00;
    grant = 8'hFF;
    arst_l = 1'b1;
    #1;
    check_eq("rel_req_b0", 32'(if_b.scache_cpx_req_buf_cq), 32'h0);
    tick();
    check_eq("rel_req_b1", 32'(if_b.scache_cpx_req_buf_cq), 32'h0);
    tick();
    check_eq("rel_req_b2", 32'(if_b.scache_cpx_req_buf_cq), 32'h0);
    set_idle();
    tick();
    check_eq("rel_req_b3", 32'(if_b.scache_cpx_req_buf_cq), 32'hFF);

    // clear coincident with a fresh overflow keeps the flag
    phase_reset();
    req_l = 8'hFE;
    repeat (7) tick();
    err_clr = 1'b1;
    tick();
    check_eq("clr_ovf_a", 32'(if_a.err_ovf[0]), 32'h1);
    check_eq("clr_ovf_b", 32'(if_b.err_ovf[0]), 32'h1);
    set_idle();
    repeat (4) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("clr_done_a", 32'(if_a.err_ovf[0]), 32'h0);

    // randomized traffic
    phase_reset();
    for (int n = 0; n < 600; n++) begin
      req_l   = ~NCH'($urandom & $urandom);
      grant   = NCH'($urandom & $urandom & $urandom);
      atom_l  = ($urandom_range(0, 7) != 0);
      err_clr = ($urandom_range(0, 15) == 0);
      tick();
      if (n == 300) phase_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
